// File: rtl/fta_bridge_wide2narrow.sv
// fta_bridge_wide2narrow
// Sequential FTA width bridge. Each wide access is split into one narrow
// beat per active narrow lane (lowest lane first), read data is collected
// into a wide buffer, and the master receives a single ack_o/err_o pulse.
// Optional feature macro: FTA_BRIDGE_TIMEOUT_EN. When it is defined, a beat
// that waits TIMEOUT cycles with no slave response is aborted as an error.
module fta_bridge_wide2narrow #(
  parameter int WID     = 256,
  parameter int NWID    = 32,
  parameter int AWID    = 32,
  parameter int TIDW    = 13,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // wide master port
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [WID/8-1:0]  sel_i,
  input  logic [AWID-1:0]   adr_i,
  input  logic [WID-1:0]    dat_i,
  input  logic [TIDW-1:0]   tid_i,
  output logic              stall_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [WID-1:0]    dat_o,
  output logic [TIDW-1:0]   tid_o,
  // narrow slave port
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [NWID/8-1:0] sel_o,
  output logic [AWID-1:0]   adr_o,
  output logic [NWID-1:0]   dat_o_n,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic [NWID-1:0]   dat_i_n
);

  localparam int NLANES = WID / NWID;
  localparam int LB     = $clog2(NLANES);
  localparam int NB     = $clog2(NWID / 8);
  localparam int NSEL   = NWID / 8;
  localparam int LW     = (LB > 0) ? LB : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_we;
  logic [WID/8-1:0]  r_sel;
  logic [AWID-1:0]   r_adr;
  logic [WID-1:0]    r_dat;
  logic [TIDW-1:0]   r_tid;
  logic [NLANES-1:0] r_mask;
  logic [WID-1:0]    r_buf;
  logic              r_err;

  logic [NLANES-1:0] w_req_mask;
  logic [NLANES-1:0] w_onehot;
  logic [NLANES-1:0] w_rest;
  logic [LW-1:0]     w_lane;
  logic [AWID-1:0]   w_adr;
  logic              w_accept;
  logic              w_tmo;
  logic              w_beat_ok;
  logic              w_beat_err;

  assign w_accept = cyc_i & stb_i;

  // One mask bit per narrow lane that has at least one byte enabled.
  always_comb begin
    w_req_mask = '0;
    for (int l = 0; l < NLANES; l++) begin
      w_req_mask[l] = |sel_i[l*NSEL +: NSEL];
    end
  end

  // Index of the lowest pending lane; scanning downward leaves the lowest.
  always_comb begin
    w_lane = '0;
    for (int l = NLANES - 1; l >= 0; l--) begin
      if (r_mask[l]) w_lane = LW'(l);
    end
  end

  assign w_onehot = r_mask & (~r_mask + NLANES'(1));
  assign w_rest   = r_mask & ~w_onehot;

  // Narrow address: wide-aligned base, lane index, byte offset zeroed.
  assign w_adr = ((r_adr >> (LB + NB)) << (LB + NB)) | (AWID'(w_lane) << NB);

`ifdef FTA_BRIDGE_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT + 1);
  logic [TMW-1:0] r_tmo;

  // Per-beat wait counter, held at zero outside ISSUE so every beat starts fresh.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                r_tmo <= '0;
    else if (r_state != ISSUE)  r_tmo <= '0;
    else                        r_tmo <= r_tmo + TMW'(1);
  end

  assign w_tmo = (r_tmo == TMW'(TIMEOUT));
`else
  // Without the counter a beat waits for the slave indefinitely.
  assign w_tmo = (TIMEOUT < 0);
`endif

  // A simultaneous ack and err counts as err; a timeout is treated as err.
  assign w_beat_err = err_i | (w_tmo & ~ack_i);
  assign w_beat_ok  = ack_i & ~err_i;

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode and all port outputs, derived from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_next  = r_state;
    stall_o = 1'b1;
    ack_o   = 1'b0;
    err_o   = 1'b0;
    dat_o   = '0;
    tid_o   = '0;
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    sel_o   = '0;
    adr_o   = '0;
    dat_o_n = '0;
    case (r_state)
      IDLE: begin
        stall_o = 1'b0;
        if (w_accept) w_next = (|w_req_mask) ? ISSUE : RESP;
      end
      ISSUE: begin
        cyc_o   = 1'b1;
        stb_o   = 1'b1;
        we_o    = r_we;
        sel_o   = r_sel[w_lane*NSEL +: NSEL];
        adr_o   = w_adr;
        dat_o_n = r_dat[w_lane*NWID +: NWID];
        if (w_beat_err)     w_next = RESP;
        else if (w_beat_ok) w_next = (|w_rest) ? GAP : RESP;
      end
      GAP: begin
        cyc_o  = 1'b1;
        we_o   = r_we;
        w_next = ISSUE;
      end
      RESP: begin
        ack_o  = ~r_err;
        err_o  = r_err;
        dat_o  = r_buf;
        tid_o  = r_tid;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture, lane bookkeeping, read-data assembly and error flag.
  always_ff @(posedge clk_i) begin
    // NOTE: the read buffer is plain flops, so it is reset and also cleared on
    // every accept; lanes that receive no read data must come back as zero.
    if (!rst_ni) begin
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_tid  <= '0;
      r_mask <= '0;
      r_buf  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we   <= we_i;
            r_sel  <= sel_i;
            r_adr  <= adr_i;
            r_dat  <= dat_i;
            r_tid  <= tid_i;
            r_mask <= w_req_mask;
            r_buf  <= '0;
            r_err  <= 1'b0;
          end
        end
        ISSUE: begin
          if (w_beat_err) begin
            r_err  <= 1'b1;
            r_mask <= '0;
          end else if (w_beat_ok) begin
            if (!r_we) r_buf[w_lane*NWID +: NWID] <= dat_i_n;
            r_mask <= w_rest;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fta_bridge_wide2narrow.sv
// Directed testbench for fta_bridge_wide2narrow (WID=256, NWID=32).
// A behavioural narrow slave answers at the falling edge with configurable
// wait states, an error on a chosen beat, or no answer at all, and logs each
// beat it answers. Expected values below are worked out by hand.
module tb_fta_bridge_wide2narrow;

  localparam int WID     = 256;
  localparam int NWID    = 32;
  localparam int AWID    = 32;
  localparam int TIDW    = 13;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cyc_i = 0, stb_i = 0, we_i = 0;
  logic [31:0]     sel_i = '0;
  logic [31:0]     adr_i = '0;
  logic [255:0]    dat_i = '0;
  logic [12:0]     tid_i = '0;
  logic            stall_o, ack_o, err_o;
  logic [255:0]    dat_o;
  logic [12:0]     tid_o;
  logic            cyc_o, stb_o, we_o;
  logic [3:0]      sel_o;
  logic [31:0]     adr_o;
  logic [31:0]     dat_o_n;
  logic            ack_i = 0, err_i = 0;
  logic [31:0]     dat_i_n = '0;

  always #5 clk = ~clk;

  fta_bridge_wide2narrow #(
    .WID(WID), .NWID(NWID), .AWID(AWID), .TIDW(TIDW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i),
    .dat_i(dat_i), .tid_i(tid_i), .stall_o(stall_o), .ack_o(ack_o),
    .err_o(err_o), .dat_o(dat_o), .tid_o(tid_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o_n(dat_o_n), .ack_i(ack_i), .err_i(err_i), .dat_i_n(dat_i_n)
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int t0 = 0;

  always @(posedge clk) cyc_cnt++;

  // slave behaviour and beat log
  int          s_wait = 0;
  int          s_err_beat = -1;
  bit          s_never = 0;
  logic [31:0] s_base = '0;
  int          s_cnt = 0;
  int          nbeats = 0;
  bit          saw_cyc = 0;
  logic [3:0]  b_sel [16];
  logic [31:0] b_adr [16];
  logic [31:0] b_dat [16];
  logic        b_we  [16];
  int          b_time[16];

  // result of the last completed wide request
  int           r_time;
  logic         r_ack, r_err;
  logic [255:0] r_dat;
  logic [12:0]  r_tid;

  always @(negedge clk) begin
    if (cyc_o) saw_cyc = 1;
    ack_i = 0; err_i = 0; dat_i_n = '0;
    if (stb_o && !s_never) begin
      if (s_cnt >= s_wait) begin
        if (nbeats < 16) begin
          b_sel[nbeats] = sel_o; b_adr[nbeats] = adr_o;
          b_dat[nbeats] = dat_o_n; b_we[nbeats] = we_o;
          b_time[nbeats] = cyc_cnt - t0;
        end
        if (nbeats == s_err_beat) err_i = 1;
        else begin
          ack_i = 1;
          dat_i_n = s_base + 32'(adr_o[4:2]);
        end
        nbeats++;
        s_cnt = 0;
      end else s_cnt++;
    end else s_cnt = 0;
  end

  task automatic do_req(input string name, input logic we, input logic [31:0] sel,
                        input logic [31:0] adr, input logic [255:0] dat, input logic [12:0] tid);
    bit done = 0;
    nbeats = 0; saw_cyc = 0; r_time = -1;
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat; tid_i = tid;
    t0 = cyc_cnt;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        done = 1; r_time = cyc_cnt - t0; r_ack = ack_o; r_err = err_o;
        r_dat = dat_o; r_tid = tid_o;
      end
    end
    cyc_i = 0; stb_i = 0; we_i = 0; sel_i = '0; adr_i = '0; dat_i = '0; tid_i = '0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s completion: no ack_o/err_o within 200 cycles", name);
    end else begin
      @(negedge clk);
      checks++;
      if ({ack_o, err_o, stall_o} !== 3'b000) begin
        errors++;
        $display("FAIL %s after_resp: got ack/err/stall=%b, want 000", name, {ack_o, err_o, stall_o});
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({stall_o, ack_o, err_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o_n, tid_o} !== '0 ||
        dat_o !== '0) begin
      errors++;
      $display("FAIL %s outputs: stall=%b ack=%b err=%b cyc=%b stb=%b we=%b sel=%h adr=%h dn=%h tid=%h dat=%h, want all 0",
               name, stall_o, ack_o, err_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o_n, tid_o, dat_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_hexi_read();
    logic [255:0] exp;
    for (int l = 0; l < 8; l++) exp[l*32 +: 32] = 32'(l);
    s_wait = 0; s_err_beat = -1; s_base = '0;
    do_req("hexi", 1'b0, 32'hFFFF_FFFF, 32'h4000_0013, '0, 13'h0ABC);
    checks++;
    if (nbeats !== 8) begin errors++; $display("FAIL hexi beats: got %0d want 8", nbeats); end
    for (int j = 0; j < 8 && j < nbeats; j++) begin
      checks++;
      if (b_adr[j] !== 32'h4000_0000 + 32'(4*j) || b_sel[j] !== 4'hF || b_time[j] !== 1 + 2*j) begin
        errors++;
        $display("FAIL hexi beat%0d: adr=%h sel=%h t=%0d, want adr=%h sel=f t=%0d",
                 j, b_adr[j], b_sel[j], b_time[j], 32'h4000_0000 + 32'(4*j), 1 + 2*j);
      end
    end
    checks++;
    if (r_time !== 16 || r_ack !== 1'b1 || r_err !== 1'b0) begin
      errors++; $display("FAIL hexi ack: t=%0d ack=%b err=%b, want t=16 ack=1 err=0", r_time, r_ack, r_err);
    end
    checks++;
    if (r_dat !== exp || r_tid !== 13'h0ABC) begin
      errors++; $display("FAIL hexi data: dat=%h tid=%h, want dat=%h tid=0abc", r_dat, r_tid, exp);
    end
  endtask

  task automatic test_sparse_write();
    logic [255:0] d = '0;
    d[31:0] = 32'hAAAA_5555;
    d[159:128] = 32'h1234_5678;
    s_wait = 0; s_err_beat = -1; s_base = 32'hDEAD_0000;
    do_req("sparse", 1'b1, 32'h000F_000F, 32'h1000_0000, d, 13'h0005);
    checks++;
    if (nbeats !== 2) begin errors++; $display("FAIL sparse beats: got %0d want 2", nbeats); end
    checks++;
    if (b_adr[0] !== 32'h1000_0000 || b_sel[0] !== 4'hF || b_dat[0] !== 32'hAAAA_5555 || b_we[0] !== 1'b1) begin
      errors++; $display("FAIL sparse beat0: adr=%h sel=%h dat=%h we=%b, want 10000000 f aaaa5555 1",
                         b_adr[0], b_sel[0], b_dat[0], b_we[0]);
    end
    checks++;
    if (b_adr[1] !== 32'h1000_0010 || b_sel[1] !== 4'hF || b_dat[1] !== 32'h1234_5678 || b_we[1] !== 1'b1) begin
      errors++; $display("FAIL sparse beat1: adr=%h sel=%h dat=%h we=%b, want 10000010 f 12345678 1",
                         b_adr[1], b_sel[1], b_dat[1], b_we[1]);
    end
    checks++;
    if (r_time !== 4 || r_ack !== 1'b1 || r_dat !== '0) begin
      errors++; $display("FAIL sparse resp: t=%0d ack=%b dat=%h, want t=4 ack=1 dat=0", r_time, r_ack, r_dat);
    end
  endtask

  task automatic test_byte_read();
    logic [255:0] exp = '0;
    exp[95:64] = 32'hC0DE_0002;
    s_wait = 2; s_err_beat = -1; s_base = 32'hC0DE_0000;
    do_req("byte", 1'b0, 32'h0000_0200, 32'h2000_0000, '0, 13'h0011);
    checks++;
    if (nbeats !== 1 || b_sel[0] !== 4'b0010 || b_adr[0] !== 32'h2000_0008) begin
      errors++; $display("FAIL byte beat: n=%0d sel=%b adr=%h, want n=1 sel=0010 adr=20000008",
                         nbeats, b_sel[0], b_adr[0]);
    end
    checks++;
    if (r_time !== 4 || r_ack !== 1'b1 || r_dat !== exp) begin
      errors++; $display("FAIL byte resp: t=%0d ack=%b dat=%h, want t=4 ack=1 dat=%h", r_time, r_ack, r_dat, exp);
    end
    s_wait = 0;
  endtask

  task automatic test_error_abort();
    logic [255:0] exp = '0;
    exp[31:0] = 32'h0000_0100;
    s_wait = 0; s_err_beat = 1; s_base = 32'h0000_0100;
    do_req("err", 1'b0, 32'h0000_FFFF, 32'h3000_0000, '0, 13'h1234);
    checks++;
    if (nbeats !== 2) begin errors++; $display("FAIL err beats: got %0d want 2", nbeats); end
    checks++;
    if (r_err !== 1'b1 || r_ack !== 1'b0 || r_tid !== 13'h1234 || r_time !== 4) begin
      errors++; $display("FAIL err resp: err=%b ack=%b tid=%h t=%0d, want err=1 ack=0 tid=1234 t=4",
                         r_err, r_ack, r_tid, r_time);
    end
    checks++;
    if (r_dat !== exp) begin errors++; $display("FAIL err data: got %h want %h", r_dat, exp); end
    s_err_beat = -1;
  endtask

  task automatic test_zero_sel();
    do_req("zero", 1'b0, 32'h0, 32'h5000_0000, '0, 13'h0777);
    checks++;
    if (r_time !== 1 || r_ack !== 1'b1 || r_tid !== 13'h0777 || nbeats !== 0 || saw_cyc !== 1'b0) begin
      errors++; $display("FAIL zero resp: t=%0d ack=%b tid=%h beats=%0d cyc_seen=%b, want 1 1 0777 0 0",
                         r_time, r_ack, r_tid, nbeats, saw_cyc);
    end
  endtask

  task automatic test_reset_mid();
    bit ack_seen = 0;
    s_never = 1;
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 0; sel_i = 32'hFFFF_FFFF; adr_i = 32'h6000_0000; tid_i = 13'h0042;
    repeat (3) @(negedge clk);
    checks++;
    if (stb_o !== 1'b1 || cyc_o !== 1'b1) begin
      errors++; $display("FAIL rstmid issue: cyc=%b stb=%b, want 1 1", cyc_o, stb_o);
    end
    rst_n = 0;
    @(negedge clk);
    check_outputs_zero("rstmid");
    cyc_i = 0; stb_i = 0; sel_i = '0; adr_i = '0; tid_i = '0;
    rst_n = 1; s_never = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_o || err_o) ack_seen = 1;
    end
    checks++;
    if (ack_seen) begin errors++; $display("FAIL rstmid ack: got a completion pulse after reset, want none"); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp = '0;
    exp[63:32]   = 32'h0000_0901;
    exp[255:224] = 32'h0000_0907;
    s_base = 32'h0000_0900;
    do_req("b2b_a", 1'b0, 32'hF000_00F0, 32'h7000_0000, '0, 13'h0101);
    checks++;
    if (r_time !== 4 || r_ack !== 1'b1 || r_dat !== exp || r_tid !== 13'h0101) begin
      errors++; $display("FAIL b2b_a resp: t=%0d ack=%b tid=%h dat=%h, want t=4 ack=1 tid=0101 dat=%h",
                         r_time, r_ack, r_tid, r_dat, exp);
    end
    do_req("b2b_b", 1'b1, 32'h0000_0F00, 32'h7000_0000, 256'h55, 13'h0102);
    checks++;
    if (r_time !== 2 || r_ack !== 1'b1 || r_dat !== '0 || r_tid !== 13'h0102 || b_adr[0] !== 32'h7000_0008) begin
      errors++; $display("FAIL b2b_b resp: t=%0d ack=%b tid=%h dat=%h adr=%h, want t=2 ack=1 tid=0102 dat=0 adr=70000008",
                         r_time, r_ack, r_tid, r_dat, b_adr[0]);
    end
  endtask

`ifdef FTA_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    s_never = 1;
    do_req("tmo", 1'b0, 32'h0000_000F, 32'h8000_0000, '0, 13'h0333);
    checks++;
    if (r_time !== 18 || r_err !== 1'b1 || r_ack !== 1'b0 || r_tid !== 13'h0333) begin
      errors++; $display("FAIL tmo resp: t=%0d err=%b ack=%b tid=%h, want t=18 err=1 ack=0 tid=0333",
                         r_time, r_err, r_ack, r_tid);
    end
    s_never = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_hexi_read();
    test_sparse_write();
    test_byte_read();
    test_error_abort();
    test_zero_sel();
    test_reset_mid();
    test_back_to_back();
`ifdef FTA_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
